// File: rtl/codec_config_seq.sv
// codec_config_seq: walks a fixed table of audio-codec register words and
// hands each {sub-address, data} word to the I2C write engine over the
// GO/ACK/READY handshake. Transfers are spaced by a fixed gap. A stalled
// engine is reported on ERR, and a completed run is reported on DONE.
module codec_config_seq #(
    parameter int NUM_REGS       = 11,
    parameter int POWERUP_CYCLES = 1024,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit AUTO_START     = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic [15:0] I2C_DATA,
    output logic        GO,
    input  logic        ACK,
    input  logic        READY,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [3:0]  INDEX
);

    localparam int PW = (POWERUP_CYCLES < 2) ? 1 : $clog2(POWERUP_CYCLES + 1);
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWRUP,
        S_LOAD,
        S_REQ,
        S_WAIT_XFER,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    logic [PW-1:0] pwr_cnt;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] tmo_cnt;

    // Codec register table: {sub-address, data}
    function automatic logic [15:0] table_word(input logic [3:0] i);
        case (i)
            4'd0:    return 16'h1E00;  // codec reset
            4'd1:    return 16'h0C00;  // power all on
            4'd2:    return 16'h0017;  // line-in L, 0 dB
            4'd3:    return 16'h0217;  // line-in R, 0 dB
            4'd4:    return 16'h047F;  // headphone L
            4'd5:    return 16'h067F;  // headphone R
            4'd6:    return 16'h0812;  // analog path
            4'd7:    return 16'h0A06;  // digital path
            4'd8:    return 16'h0E02;  // I2S, 16-bit
            4'd9:    return 16'h1000;  // 48 kHz normal
            4'd10:   return 16'h1201;  // active
            default: return 16'h0000;
        endcase
    endfunction

    // Sequencer FSM; every output is registered and changes with the state.
    // Counters only advance below their terminal value, so they saturate.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= AUTO_START ? S_PWRUP : S_IDLE;
            GO       <= 1'b0;
            I2C_DATA <= 16'h0000;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            INDEX    <= 4'd0;
            pwr_cnt  <= '0;
            gap_cnt  <= '0;
            tmo_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state <= S_LOAD;
                        INDEX <= 4'd0;
                        DONE  <= 1'b0;
                        ERR   <= 1'b0;
                        BUSY  <= 1'b1;
                    end
                end
                S_PWRUP: begin
                    BUSY <= 1'b1;
                    if (int'(pwr_cnt) + 1 >= POWERUP_CYCLES) begin
                        state <= S_LOAD;
                        INDEX <= 4'd0;
                    end else begin
                        pwr_cnt <= pwr_cnt + PW'(1);
                    end
                end
                S_LOAD: begin
                    I2C_DATA <= table_word(INDEX);
                    tmo_cnt  <= '0;
                    GO       <= 1'b1;
                    state    <= S_REQ;
                end
                S_REQ: begin
                    // ACK has priority over READY: READY may still be high
                    // from before this transfer started.
                    if (ACK) begin
                        GO      <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= S_WAIT_XFER;
                    end else if (int'(tmo_cnt) + 1 >= TIMEOUT_CYCLES) begin
                        GO    <= 1'b0;
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_WAIT_XFER: begin
                    if (READY) begin
                        if (INDEX >= 4'(NUM_REGS - 1)) begin
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end else if (int'(tmo_cnt) + 1 >= TIMEOUT_CYCLES) begin
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_GAP: begin
                    if (int'(gap_cnt) + 1 >= GAP_CYCLES) begin
                        if (INDEX < 4'(NUM_REGS - 1)) begin
                            INDEX <= INDEX + 4'd1;
                        end
                        state <= S_LOAD;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                S_DONE: begin
                    if (START) begin
                        state <= S_LOAD;
                        INDEX <= 4'd0;
                        DONE  <= 1'b0;
                        BUSY  <= 1'b1;
                    end
                end
                S_ERROR: begin
                    if (START) begin
                        state <= S_LOAD;
                        INDEX <= 4'd0;
                        ERR   <= 1'b0;
                        BUSY  <= 1'b1;
                    end
                end
                default: begin
                    GO    <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_config_seq.sv
// Bench for codec_config_seq: an auto-start instance and a manual-start
// instance, each driven by a behavioural I2C engine responder.
module tb_codec_config_seq;

    localparam int P = 16;
    localparam int G = 4;
    localparam int T = 255;
    localparam int N = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst, start, ack, ready;
    logic        go_a, busy_a, done_a, err_a;
    logic        go_m, busy_m, done_m, err_m;
    logic [15:0] data_a, data_m;
    logic [3:0]  idx_a, idx_m;

    codec_config_seq #(
        .NUM_REGS(N), .POWERUP_CYCLES(P), .GAP_CYCLES(G),
        .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)
    ) u_auto (
        .CLK(clk), .RST(rst[0]), .START(start[0]), .I2C_DATA(data_a),
        .GO(go_a), .ACK(ack[0]), .READY(ready[0]), .BUSY(busy_a),
        .DONE(done_a), .ERR(err_a), .INDEX(idx_a)
    );

    codec_config_seq #(
        .NUM_REGS(N), .POWERUP_CYCLES(P), .GAP_CYCLES(G),
        .TIMEOUT_CYCLES(T), .AUTO_START(1'b0)
    ) u_man (
        .CLK(clk), .RST(rst[1]), .START(start[1]), .I2C_DATA(data_m),
        .GO(go_m), .ACK(ack[1]), .READY(ready[1]), .BUSY(busy_m),
        .DONE(done_m), .ERR(err_m), .INDEX(idx_m)
    );

    // Per-word stimulus and expectation: engine ACK delay after GO is first
    // seen, READY-low length after ACK, and the word that must be offered.
    typedef struct {
        int          ack_dly;
        int          busy_len;
        logic [15:0] word;
    } vec_t;
    vec_t vecs [N];

    int checks = 0;
    int failures = 0;

    // Count GO rising edges per instance
    logic [1:0] go_q = 2'b00;
    int rises_a = 0;
    int rises_m = 0;
    always @(negedge clk) begin
        go_q <= {go_m, go_a};
        if (go_a && !go_q[0]) rises_a <= rises_a + 1;
        if (go_m && !go_q[1]) rises_m <= rises_m + 1;
    end

    function automatic logic f_go(input int s);
        return (s != 0) ? go_m : go_a;
    endfunction
    function automatic logic f_busy(input int s);
        return (s != 0) ? busy_m : busy_a;
    endfunction
    function automatic logic f_done(input int s);
        return (s != 0) ? done_m : done_a;
    endfunction
    function automatic logic f_err(input int s);
        return (s != 0) ? err_m : err_a;
    endfunction
    function automatic logic [15:0] f_data(input int s);
        return (s != 0) ? data_m : data_a;
    endfunction
    function automatic logic [3:0] f_idx(input int s);
        return (s != 0) ? idx_m : idx_a;
    endfunction
    function automatic int f_rises(input int s);
        return (s != 0) ? rises_m : rises_a;
    endfunction

    task automatic chk(input string name, input int s, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d actual=%0h required=%0h", name, s, act, exp);
        end
    endtask

    task automatic fail_bound(input string name, input int s);
        checks++;
        failures++;
        $display("FAIL %s dut=%0d actual=no event required=event within bound", name, s);
    endtask

    // Returns the number of falling edges waited until GO is seen, or -1
    task automatic wait_go(input int s, output int n);
        n = -1;
        for (int k = 1; k <= 1500; k++) begin
            @(negedge clk);
            if (f_go(s)) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic pulse_start(input int s);
        start[s] = 1'b1;
        @(negedge clk);
        start[s] = 1'b0;
    endtask

    // Engine responder for one word; called at the falling edge where GO is first seen
    task automatic respond(input int s, input int i, input bit noise);
        logic [15:0] w;
        int          gh;
        bit          bad;
        w   = f_data(s);
        gh  = 1;
        bad = 1'b0;
        chk("word", s, w, vecs[i].word);
        chk("index", s, f_idx(s), i);
        for (int k = 0; k < vecs[i].ack_dly; k++) begin
            @(negedge clk);
            if (f_go(s)) gh++;
            if (f_data(s) != w) bad = 1'b1;
        end
        // ACK sampled together with a still-high READY
        ack[s] = 1'b1;
        @(negedge clk);
        ack[s]   = 1'b0;
        ready[s] = 1'b0;
        chk("go_fall", s, f_go(s), 0);
        chk("go_width", s, gh, vecs[i].ack_dly + 1);
        for (int k = 0; k < vecs[i].busy_len; k++) begin
            if (noise && i == 5 && k == 2) start[s] = 1'b1;
            if (noise && i == 5 && k == 3) start[s] = 1'b0;
            @(negedge clk);
            if (f_data(s) != w || f_go(s)) bad = 1'b1;
        end
        ready[s] = 1'b1;
        chk("data_stable", s, bad, 0);
    endtask

    // Serve nw words; first_exp < 0 skips the first GO latency check.
    // Between words GO must appear G+2 falling edges after READY returns:
    // G cycles in GAP, one in LOAD, then GO.
    task automatic run_table(input int s, input int first_exp, input int nw, input bit noise);
        int n;
        for (int i = 0; i < nw; i++) begin
            wait_go(s, n);
            if (n < 0) begin
                fail_bound("go_seen", s);
                return;
            end
            if (i == 0) begin
                if (first_exp >= 0) chk("first_go_latency", s, n, first_exp);
            end else begin
                chk("gap", s, n, G + 2);
            end
            respond(s, i, noise);
        end
    endtask

    task automatic end_checks(input int s);
        @(negedge clk);
        chk("done_set", s, f_done(s), 1);
        chk("busy_end", s, f_busy(s), 0);
        chk("index_end", s, f_idx(s), N - 1);
        chk("err_end", s, f_err(s), 0);
        chk("go_end", s, f_go(s), 0);
    endtask

    initial begin
        int n;
        int gh;
        int base;
        bit seen;

        vecs[0]  = '{3, 33, 16'h1E00};
        vecs[1]  = '{3, 33, 16'h0C00};
        vecs[2]  = '{0,  1, 16'h0017};
        vecs[3]  = '{3, 33, 16'h0217};
        vecs[4]  = '{20, 33, 16'h047F};
        vecs[5]  = '{3, 33, 16'h067F};
        vecs[6]  = '{1,  5, 16'h0812};
        vecs[7]  = '{3, 33, 16'h0A06};
        vecs[8]  = '{2, 10, 16'h0E02};
        vecs[9]  = '{3, 33, 16'h1000};
        vecs[10] = '{3, 33, 16'h1201};

        rst   = 2'b11;
        start = 2'b00;
        ack   = 2'b00;
        ready = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_go", s, f_go(s), 0);
            chk("rst_data", s, f_data(s), 16'h0000);
            chk("rst_busy", s, f_busy(s), 0);
            chk("rst_done", s, f_done(s), 0);
            chk("rst_err", s, f_err(s), 0);
            chk("rst_index", s, f_idx(s), 0);
        end

        // Auto-start nominal run. Released in cycle 1 after the last reset
        // edge, so GO in cycle P+2 is seen P+1 falling edges later.
        rst[0] = 1'b0;
        base = rises_a;
        run_table(0, P + 1, N, 1'b0);
        end_checks(0);
        chk("word_count", 0, rises_a - base, N);

        // Rerun from DONE, then never ACK word 3
        pulse_start(0);
        chk("done_clear", 0, done_a, 0);
        chk("busy_run", 0, busy_a, 1);
        run_table(0, 1, 3, 1'b0);
        wait_go(0, n);
        if (n < 0) begin
            fail_bound("go_seen_w3", 0);
        end else begin
            chk("gap", 0, n, G + 2);
            chk("word3", 0, data_a, 16'h0217);
            gh   = 1;
            seen = 1'b0;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (err_a) begin
                    seen = 1'b1;
                    break;
                end
                if (go_a) gh++;
            end
            chk("err_seen", 0, seen, 1);
            chk("timeout_len", 0, gh, T);
            chk("err_go", 0, go_a, 0);
            chk("err_index", 0, idx_a, 3);
            chk("err_done", 0, done_a, 0);
            chk("err_busy", 0, busy_a, 0);
        end

        // Recovery from ERROR
        pulse_start(0);
        chk("err_clear", 0, err_a, 0);
        chk("err_busy_run", 0, busy_a, 1);
        base = rises_a;
        run_table(0, 1, N, 1'b0);
        end_checks(0);
        chk("word_count", 0, rises_a - base, N);

        // Reset during WAIT_XFER of word 5
        pulse_start(0);
        run_table(0, 1, 5, 1'b0);
        wait_go(0, n);
        if (n < 0) fail_bound("go_seen_w5", 0);
        chk("word5", 0, data_a, 16'h067F);
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0]   = 1'b0;
        ready[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0]   = 1'b0;
        ready[0] = 1'b1;
        chk("mid_rst_go", 0, go_a, 0);
        chk("mid_rst_index", 0, idx_a, 0);
        chk("mid_rst_busy", 0, busy_a, 0);
        chk("mid_rst_done", 0, done_a, 0);
        chk("mid_rst_err", 0, err_a, 0);
        base = rises_a;
        run_table(0, P + 1, N, 1'b0);
        end_checks(0);
        chk("word_count", 0, rises_a - base, N);

        // Manual mode: nothing happens without START, stray ACK ignored
        rst[1] = 1'b0;
        base = rises_m;
        repeat (1000) @(negedge clk);
        ack[1] = 1'b1;
        @(negedge clk);
        ack[1] = 1'b0;
        repeat (999) @(negedge clk);
        chk("idle_no_go", 1, rises_m - base, 0);
        chk("idle_busy", 1, busy_m, 0);
        chk("idle_go", 1, go_m, 0);
        chk("idle_done", 1, done_m, 0);

        // START, then extra STARTs while busy must not disturb the run
        pulse_start(1);
        chk("man_busy", 1, busy_m, 1);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        run_table(1, -1, N, 1'b1);
        end_checks(1);
        chk("word_count", 1, rises_m - base, N);

        // START from DONE reruns the table
        base = rises_m;
        pulse_start(1);
        chk("done_clear", 1, done_m, 0);
        run_table(1, 1, N, 1'b0);
        end_checks(1);
        chk("word_count", 1, rises_m - base, N);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/codec_config_seq.md
Name: codec_config_seq

Overview:
- Upstream stage of the I2C write engine. After reset or on request, walks a fixed table of audio-codec register words.
- Hands each 16-bit word, formatted {sub-address, data}, to the I2C engine through the GO/ACK/READY handshake.
- Spaces consecutive transfers, detects a stalled engine, and reports DONE or ERR to the top level.

Parameters:
- NUM_REGS, 11: table entries sent per run (1..16).
- POWERUP_CYCLES, 1024: CLK cycles between leaving reset and the first transfer when AUTO_START=1.
- GAP_CYCLES, 4: idle CLK cycles between READY returning high and the next GO.
- TIMEOUT_CYCLES, 255: max cycles allowed in REQ or WAIT_XFER before ERR.
- AUTO_START, 1: 1 runs the table automatically after reset; 0 waits for START.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  single-cycle pulse; (re)runs the table from entry 0 when in IDLE, DONE or ERROR; ignored otherwise.
- I2C_DATA  output  16  word for the I2C engine: [15:8] sub-address, [7:0] data.
- GO  output  1  transfer request to the I2C engine.
- ACK  input  1  engine accepted the command; one-cycle pulse.
- READY  input  1  engine idle / previous transfer complete.
- BUSY  output  1  high whenever the state is not IDLE, DONE or ERROR.
- DONE  output  1  all NUM_REGS words sent; held until START or RST.
- ERR  output  1  timeout occurred; held until START or RST.
- INDEX  output  4  table entry currently being sent, or last attempted.

Behaviour:
- Reset, synchronous, active-high, takes priority over everything including mid-transfer.
  - Outputs cleared: GO=0, I2C_DATA=16'h0000, BUSY=0, DONE=0, ERR=0, INDEX=0.
  - All counters cleared.
  - Next state: PWRUP if AUTO_START=1, else IDLE.
- Default table (index: word):
  - 0:1E00 (codec reset)
  - 1:0C00 (power all on)
  - 2:0017
  - 3:0217 (line-in L/R, 0 dB)
  - 4:047F
  - 5:067F (headphone L/R)
  - 6:0812 (analog path)
  - 7:0A06 (digital path)
  - 8:0E02 (I2S, 16-bit)
  - 9:1000 (48 kHz normal)
  - 10:1201 (active)
  - Entries >= NUM_REGS are never sent.
- States:
  - IDLE: GO=0. START -> LOAD with INDEX=0, DONE=0, ERR=0.
  - PWRUP: counter counts POWERUP_CYCLES; at terminal count -> LOAD with INDEX=0. START is ignored.
  - LOAD: I2C_DATA <= table[INDEX]; timeout counter cleared; -> REQ. Lasts one cycle.
  - REQ: GO=1; I2C_DATA stable.
    - ACK=1 -> WAIT_XFER with GO=0 on the next cycle.
    - Timeout counter reaches TIMEOUT_CYCLES -> ERROR.
  - WAIT_XFER: GO=0; I2C_DATA held. Stays at least 1 cycle.
    - READY=1 -> GAP if INDEX<NUM_REGS-1, else DONE.
    - Timeout counter reaches TIMEOUT_CYCLES -> ERROR.
  - GAP: counts GAP_CYCLES with GO=0, then INDEX+1 -> LOAD.
  - DONE: DONE=1, GO=0. START -> LOAD with INDEX=0, DONE=0.
  - ERROR: ERR=1, GO=0, INDEX frozen at the failing entry. START -> LOAD with INDEX=0, ERR=0.
- Handshake rules:
  - GO rises no earlier than the cycle after LOAD.
  - GO stays high through the cycle in which ACK is sampled high, and falls the next cycle.
  - This guarantees the engine sees exactly one request per word.
- ACK and READY sampled together (ACK=1 while READY=1 in REQ): ACK wins. The FSM goes to WAIT_XFER and does not consider READY until the following cycle, because READY may still be high from before the transfer.
- READY low throughout REQ is legal; only ACK is tested there.
- ACK pulse while not in REQ: ignored.
- START while BUSY: ignored, and the run is unaffected.
- All counters saturate; INDEX never wraps past NUM_REGS-1.
- Latency, first word with AUTO_START=1: GO first high at cycle POWERUP_CYCLES+2 after RST deasserts.

Test Plan:
- Nominal run: AUTO_START=1, POWERUP_CYCLES=16, behavioural engine responder (ACK 3 cycles after GO, READY low 33 cycles) -> 11 GO pulses carrying 1E00, 0C00, 0017 … 1201 in order; DONE=1 and BUSY=0 after the last READY; INDEX=10.
- Handshake timing: responder delays ACK by 20 cycles -> GO stays high exactly 21 cycles and falls the cycle after ACK; I2C_DATA is unchanged from GO rising to READY returning.
- ACK timeout: responder never ACKs word 3 -> ERR=1 exactly TIMEOUT_CYCLES cycles into REQ; GO=0; INDEX=3; DONE=0.
- Recovery: in ERROR, pulse START with a good responder -> ERR clears the next cycle and all 11 words are resent from 1E00; ends with DONE=1.
- Reset mid-transfer: assert RST during WAIT_XFER of word 5 -> the next cycle shows GO=0, INDEX=0, BUSY=0, DONE=0, ERR=0; the run restarts after POWERUP_CYCLES.
- Manual mode: AUTO_START=0 -> no GO for 2000 cycles after reset; START pulses while BUSY are ignored (word count stays 11); START from DONE reruns the table.
